// File: rtl/ir_queue_if.sv
// rtl/ir_queue_if.sv - fetch/decode bus bundle for the instruction prefetch queue
interface ir_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]               din;
    logic                           write;
    logic                           writeb;
    logic                           writeu;
    logic                           read;
    logic                           flush;
    logic [WIDTH-1:0]               dout;
    logic                           valid;
    logic                           full;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           ovf;

    // Fetch/decode side: drives commands, observes the head entry and status.
    modport master (
        output din, write, writeb, writeu, read, flush,
        input  dout, valid, full, count, ovf
    );

    // Queue side.
    modport slave (
        input  din, write, writeb, writeu, read, flush,
        output dout, valid, full, count, ovf
    );
endinterface

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - DEPTH-entry instruction prefetch queue with byte assembly and head upper-byte patch
module ir_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ir_queue_if.slave   q
);
    localparam int NB = WIDTH / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(NB);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             valid;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_word;
    logic [WIDTH-1:0] asm_lane;

    assign valid = (count_q != '0);
    assign full  = (count_q == DEPTH_C);

    // Next-state: flush clears everything; otherwise resolve push, pop, byte assembly and head patch.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        ovf_d      = ovf_q;
        mem_d      = mem_q;
        push       = 1'b0;
        push_word  = '0;
        pop        = 1'b0;
        // Assembly register with the incoming byte dropped into the current lane.
        asm_lane   = asm_q;
        asm_lane[{byte_idx_q, 3'b000} +: 8] = q.din[7:0];

        if (q.flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            byte_idx_d = '0;
            asm_d      = '0;
            ovf_d      = 1'b0;
        end else begin
            // Full-word write has priority; a coincident writeb byte is silently dropped.
            if (q.write) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_word = q.din;
                end
            end else if (q.writeb) begin
                if (full) begin
                    ovf_d = 1'b1;
                end else if (byte_idx_q == LAST_IDX) begin
                    push       = 1'b1;
                    push_word  = asm_lane;
                    byte_idx_d = '0;
                    asm_d      = '0;
                end else begin
                    asm_d      = asm_lane;
                    byte_idx_d = byte_idx_q + BW'(1);
                end
            end

            pop = q.read && valid;

            if (push) begin
                mem_d[tail_q] = push_word;
                tail_d        = tail_q + PW'(1);
            end

            // Tail never equals head while non-empty and not full, so this never collides with the push.
            if (q.writeu && valid && !q.read) begin
                mem_d[head_q][WIDTH-1 -: 8] = q.din[7:0];
            end

            if (pop) begin
                head_d = head_q + PW'(1);
            end

            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state with asynchronous reset; a partial word is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            ovf_q      <= ovf_d;
        end
    end

    // Entry storage is not reset; dout gating hides stale contents when empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q.dout  = valid ? mem_q[head_q] : '0;
    assign q.valid = valid;
    assign q.full  = full;
    assign q.count = count_q;
    assign q.ovf   = ovf_q;
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed self-checking bench for ir_queue
module tb_ir_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   vec = 0;
    int   err = 0;

    always #5 clk = ~clk;

    ir_queue_if #(.WIDTH(16), .DEPTH(4)) a ();
    ir_queue_if #(.WIDTH(32), .DEPTH(4)) b ();

    ir_queue #(.WIDTH(16), .DEPTH(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .q(a));
    ir_queue #(.WIDTH(32), .DEPTH(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .q(b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a.din = '0; a.write = 0; a.writeb = 0; a.writeu = 0; a.read = 0; a.flush = 0;
        b.din = '0; b.write = 0; b.writeb = 0; b.writeu = 0; b.read = 0; b.flush = 0;
    endtask

    task automatic cyc_a(input logic [15:0] d, input logic w, input logic wb,
                         input logic wu, input logic rd, input logic fl);
        a.din = d; a.write = w; a.writeb = wb; a.writeu = wu; a.read = rd; a.flush = fl;
        tick();
        idle();
    endtask

    task automatic cyc_b(input logic [31:0] d, input logic wb, input logic wu);
        b.din = d; b.writeb = wb; b.writeu = wu;
        tick();
        idle();
    endtask

    task automatic test_reset;
        cyc_a(16'h1234, 1, 0, 0, 0, 0);
        vec++; if (a.dout !== 16'h1234) begin err++; $display("FAIL latency_dout got %h want 1234", a.dout); end
        cyc_a(16'h0055, 0, 1, 0, 0, 0);
        vec++; if (a.count !== 3'd1) begin err++; $display("FAIL pre_reset_count got %0d want 1", a.count); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (a.dout !== 16'h0000) begin err++; $display("FAIL reset_dout got %h want 0000", a.dout); end
        vec++; if (a.valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b want 0", a.valid); end
        vec++; if (a.count !== 3'd0) begin err++; $display("FAIL reset_count got %0d want 0", a.count); end
        vec++; if (a.ovf !== 1'b0 || a.full !== 1'b0) begin err++; $display("FAIL reset_flags got ovf=%b full=%b want 0 0", a.ovf, a.full); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a(16'h0034, 0, 1, 0, 0, 0);
        cyc_a(16'h0012, 0, 1, 0, 0, 0);
        vec++; if (a.dout !== 16'h1234 || a.count !== 3'd1) begin err++; $display("FAIL reset_discard got dout=%h count=%0d want 1234 1", a.dout, a.count); end
        cyc_a(16'h0000, 0, 0, 0, 1, 0);
        cyc_a(16'h0000, 0, 0, 0, 1, 0);
        vec++; if (a.count !== 3'd0 || a.ovf !== 1'b0) begin err++; $display("FAIL read_empty got count=%0d ovf=%b want 0 0", a.count, a.ovf); end
    endtask

    task automatic test_fill_overflow;
        logic [15:0] exp [4];
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333; exp[3] = 16'h4444;
        for (int i = 0; i < 4; i++) cyc_a(exp[i], 1, 0, 0, 0, 0);
        vec++; if (a.full !== 1'b1 || a.count !== 3'd4 || a.ovf !== 1'b0) begin err++; $display("FAIL fill_status got full=%b count=%0d ovf=%b want 1 4 0", a.full, a.count, a.ovf); end
        cyc_a(16'h5555, 1, 0, 0, 0, 0);
        vec++; if (a.ovf !== 1'b1 || a.count !== 3'd4 || a.full !== 1'b1) begin err++; $display("FAIL overflow got ovf=%b count=%0d full=%b want 1 4 1", a.ovf, a.count, a.full); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (a.dout !== exp[i]) begin err++; $display("FAIL drain_%0d got %h want %h", i, a.dout, exp[i]); end
            cyc_a(16'h0000, 0, 0, 0, 1, 0);
        end
        vec++; if (a.valid !== 1'b0 || a.dout !== 16'h0000 || a.ovf !== 1'b1) begin err++; $display("FAIL drained got valid=%b dout=%h ovf=%b want 0 0000 1", a.valid, a.dout, a.ovf); end
        cyc_a(16'hAAAA, 1, 0, 0, 0, 0);
        vec++; if (a.dout !== 16'hAAAA || a.count !== 3'd1) begin err++; $display("FAIL wrap got dout=%h count=%0d want aaaa 1", a.dout, a.count); end
        cyc_a(16'h0000, 0, 0, 0, 0, 1);
        vec++; if (a.ovf !== 1'b0 || a.count !== 3'd0) begin err++; $display("FAIL flush_clear got ovf=%b count=%0d want 0 0", a.ovf, a.count); end
    endtask

    task automatic test_writeu;
        cyc_a(16'h00CD, 1, 0, 0, 0, 0);
        cyc_a(16'h00AB, 0, 0, 1, 0, 0);
        vec++; if (a.dout !== 16'hABCD) begin err++; $display("FAIL patch got %h want abcd", a.dout); end
        cyc_a(16'h1111, 1, 0, 0, 0, 0);
        cyc_a(16'h0077, 0, 0, 1, 1, 0);
        vec++; if (a.dout !== 16'h1111 || a.count !== 3'd1) begin err++; $display("FAIL patch_with_read got dout=%h count=%0d want 1111 1", a.dout, a.count); end
        cyc_a(16'h0000, 0, 0, 0, 1, 0);
        cyc_a(16'h2222, 1, 0, 1, 0, 0);
        vec++; if (a.dout !== 16'h2222) begin err++; $display("FAIL patch_empty got %h want 2222", a.dout); end
        cyc_a(16'h3366, 1, 0, 1, 0, 0);
        vec++; if (a.dout !== 16'h6622 || a.count !== 3'd2) begin err++; $display("FAIL patch_with_push got dout=%h count=%0d want 6622 2", a.dout, a.count); end
        cyc_a(16'h0000, 0, 0, 0, 1, 0);
        vec++; if (a.dout !== 16'h3366) begin err++; $display("FAIL patch_second got %h want 3366", a.dout); end
        cyc_a(16'h0000, 0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp [4];
        exp[0] = 16'h0202; exp[1] = 16'h0303; exp[2] = 16'h0404; exp[3] = 16'h1234;
        cyc_a(16'h0101, 1, 0, 0, 0, 0);
        cyc_a(16'h0202, 1, 0, 0, 0, 0);
        cyc_a(16'h0303, 1, 0, 0, 1, 0);
        vec++; if (a.count !== 3'd2 || a.dout !== 16'h0202) begin err++; $display("FAIL push_pop got count=%0d dout=%h want 2 0202", a.count, a.dout); end
        cyc_a(16'h0034, 0, 1, 0, 0, 0);
        cyc_a(16'h0404, 1, 1, 0, 0, 0);
        vec++; if (a.count !== 3'd3 || a.ovf !== 1'b0) begin err++; $display("FAIL write_writeb got count=%0d ovf=%b want 3 0", a.count, a.ovf); end
        cyc_a(16'h0012, 0, 1, 0, 0, 0);
        vec++; if (a.count !== 3'd4) begin err++; $display("FAIL asm_kept got count=%0d want 4", a.count); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (a.dout !== exp[i]) begin err++; $display("FAIL b2b_order_%0d got %h want %h", i, a.dout, exp[i]); end
            cyc_a(16'h0000, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) cyc_a(16'h0F00 + 16'(i), 1, 0, 0, 0, 0);
        cyc_a(16'h0056, 0, 1, 0, 0, 0);
        vec++; if (a.ovf !== 1'b1 || a.count !== 3'd4) begin err++; $display("FAIL writeb_full got ovf=%b count=%0d want 1 4", a.ovf, a.count); end
        cyc_a(16'h0000, 0, 0, 0, 1, 0);
        cyc_a(16'h0034, 0, 1, 0, 0, 0);
        vec++; if (a.count !== 3'd3 || a.ovf !== 1'b1) begin err++; $display("FAIL pre_flush got count=%0d ovf=%b want 3 1", a.count, a.ovf); end
        cyc_a(16'h7777, 1, 1, 1, 1, 1);
        vec++; if (a.count !== 3'd0 || a.valid !== 1'b0 || a.ovf !== 1'b0 || a.dout !== 16'h0000) begin err++; $display("FAIL flush got count=%0d valid=%b ovf=%b dout=%h want 0 0 0 0000", a.count, a.valid, a.ovf, a.dout); end
        cyc_a(16'h0099, 0, 1, 0, 0, 0);
        vec++; if (a.count !== 3'd0) begin err++; $display("FAIL post_flush_half got count=%0d want 0", a.count); end
        cyc_a(16'h0088, 0, 1, 0, 0, 0);
        vec++; if (a.dout !== 16'h8899 || a.count !== 3'd1) begin err++; $display("FAIL post_flush_word got dout=%h count=%0d want 8899 1", a.dout, a.count); end
    endtask

    task automatic test_wide;
        logic [7:0] bytes [4];
        bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
        for (int i = 0; i < 3; i++) begin
            cyc_b({24'h0, bytes[i]}, 1, 0);
            vec++; if (b.count !== 3'd0) begin err++; $display("FAIL wide_early_%0d got count=%0d want 0", i, b.count); end
        end
        cyc_b({24'h0, bytes[3]}, 1, 0);
        vec++; if (b.dout !== 32'h12345678 || b.count !== 3'd1) begin err++; $display("FAIL wide_word got dout=%h count=%0d want 12345678 1", b.dout, b.count); end
        cyc_b(32'h000000AB, 0, 1);
        vec++; if (b.dout !== 32'hAB345678) begin err++; $display("FAIL wide_patch got %h want ab345678", b.dout); end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        test_reset();
        test_fill_overflow();
        test_writeu();
        test_back_to_back();
        test_flush();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-word instruction register: a DEPTH-entry instruction prefetch queue, WIDTH bits per entry, sitting between fetch and decode.
- Fetch can load a full word, or assemble a word byte-serially from an 8-bit bus.
- Decode sees the head word with a valid/read handshake.
- The upper-byte patch of the head entry (writeu) is retained, so existing immediate-load sequences still work.

Parameters:
- WIDTH, 16: entry width in bits. Multiple of 8, at least 16.
- DEPTH, 4: number of entries. Power of 2, at least 2.

Ports:
- clk  in  1: clock; all state changes on posedge.
- rst_n  in  1: asynchronous active-low reset.
- din  in  WIDTH: write data. Byte operations use din[7:0].
- write  in  1: push din as one full entry.
- writeb  in  1: shift din[7:0] into the assembly register.
- writeu  in  1: overwrite the top byte of the head entry, [WIDTH-1:WIDTH-8], with din[7:0].
- read  in  1: decode consumes the head entry.
- flush  in  1: synchronous clear (branch taken).
- dout  out  WIDTH: head entry; 0 when the queue is empty.
- valid  out  1: queue not empty.
- full  out  1: count == DEPTH.
- count  out  $clog2(DEPTH+1): number of entries held.
- ovf  out  1: sticky overflow flag.

Behaviour:
Reset and flush:
- While rst_n = 0 (asynchronous): head pointer, tail pointer, count, byte index, assembly register and ovf all clear to 0, so valid = 0, full = 0, dout = 0.
- Storage RAM is not reset. dout is gated by valid, so it reads 0 when empty.
- Reset asserted mid-assembly discards the partial word.
- flush = 1 at posedge: same clearing as reset, including ovf, and the byte index returns to 0.
- During a flush cycle, write, writeb, writeu and read are all ignored.

Accept and pop rules:
- Accept condition is !full. A pop in the same cycle does not free space for a push.
- write with !full: mem[tail] <= din, tail++, and count increments.
- write while full: entry dropped and ovf <= 1.
- writeb with !full: the byte lands in lane byte_idx of the assembly register, little-endian, so the first byte goes to [7:0].
- On the final byte (byte_idx == WIDTH/8-1) the complete word, with din[7:0] in the top lane, is pushed in that same cycle and byte_idx returns to 0. Otherwise byte_idx increments.
- writeb while full: byte dropped, byte_idx unchanged, ovf <= 1.
- write and writeb in the same cycle: write wins. The writeb byte is dropped and assembly state is unchanged; ovf is not set for the dropped byte.
- read with valid: head++ and count decrements. read while empty is ignored and does not set ovf.
- Push and pop in the same cycle (not full, valid): count is unchanged and both pointers advance.

writeu:
- With valid and no read in the same cycle: mem[head][WIDTH-1:WIDTH-8] <= din[7:0]; the other bits are preserved.
- Ignored when empty, and ignored when read is also asserted.
- A push in the same cycle does not make the queue non-empty for writeu.
- writeu may coincide with write or writeb; both take effect.

Timing and widths:
- Latency: data pushed at posedge N is visible on dout/valid after posedge N, provided the queue was empty. dout is combinational from mem[head].
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- count is updated with +1/-1 only, never wraps, and is bounded to 0..DEPTH.

Test Plan:
- Reset/empty: WIDTH=16, DEPTH=4. Pulse rst_n low asynchronously between clock edges. Required: dout=0, valid=0, count=0, ovf=0 immediately, without waiting for a clock edge.
- Fill/overflow/wrap: write 0x1111, 0x2222, 0x3333, 0x4444, then 0x5555. Required: full=1, count=4, ovf=1, 0x5555 lost. Then read four times, giving dout 0x1111, 0x2222, 0x3333, 0x4444. Then write 0xAAAA; required: dout=0xAAAA, which checks pointer wrap.
- Byte assembly: writeb 0x34, then writeb 0x12. Required: after the second edge, count=1 and dout=0x1234. For WIDTH=32, bytes 0x78, 0x56, 0x34, 0x12 give 0x12345678, with no push before the 4th byte.
- Upper patch: head = 0x00CD; writeu with din=0x00AB. Required: dout=0xABCD.
- Upper patch ignored: writeu while empty, or together with read. Required: no change to any entry.
- Simultaneous events: at count=2, assert write and read together; required count stays 2. Assert write and writeb together; required: only the write word is pushed and byte_idx is unchanged.
- Flush mid-assembly: after writeb 0x34, flush with count=3 and ovf=1. Required: count=0, valid=0, ovf=0. A following writeb 0x99 then writeb 0x88 gives dout=0x8899.
